// File: rtl/simplerisc_dmem_arbiter_pkg.sv
// simplerisc_dmem_arbiter_pkg: FSM state encodings and requester port ids for the data-memory arbiter
package simplerisc_dmem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/arb_rr2_pick.sv
// arb_rr2_pick: two-way round-robin winner select; ptr only breaks ties
module arb_rr2_pick (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic valid,
    output logic winner
);
    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/simplerisc_dmem_arbiter.sv
// simplerisc_dmem_arbiter: round-robin arbiter and sequencer for the single data-memory port
module simplerisc_dmem_arbiter
    import simplerisc_dmem_arbiter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    state_t        r_state, w_next;
    logic          r_ptr, r_id, r_we;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          w_valid, w_winner, w_acc, w_resp, w_take;

    arb_rr2_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .winner (w_winner)
    );

    assign w_acc  = r_state == ACCESS;
    assign w_resp = r_state == RESP;
    assign w_take = r_state == IDLE && w_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)   ? (w_valid ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? (r_we ? IDLE : WAIT) :
                 (r_state == WAIT)   ? (r_cnt == 2'd0 ? RESP : WAIT) : IDLE;
    end

    // Request fields are captured only in IDLE so in-flight accesses ignore requester changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= PORT_CPU;
            r_id    <= PORT_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 2'd0;
        end else begin
            if (w_take) begin
                r_id    <= w_winner;
                r_we    <= w_winner ? we1 : we0;
                r_addr  <= w_winner ? addr1 : addr0;
                r_wdata <= w_winner ? wdata1 : wdata0;
                r_ptr   <= ~w_winner;
            end
            if (w_acc) r_cnt <= LAT_LOAD;
            else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
        end
    end

    assign gnt0      = w_acc && r_id == PORT_CPU;
    assign gnt1      = w_acc && r_id == PORT_DMA;
    assign rvalid0   = w_resp && r_id == PORT_CPU;
    assign rvalid1   = w_resp && r_id == PORT_DMA;
    assign rdata     = w_resp ? mem_rdata : '0;
    assign mem_en    = w_acc;
    assign mem_we    = w_acc & r_we;
    assign mem_addr  = w_acc ? r_addr : '0;
    assign mem_wdata = w_acc ? r_wdata : '0;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_simplerisc_dmem_arbiter.sv
// tb_simplerisc_dmem_arbiter: table-driven and directed checks on MEM_LAT=1 and MEM_LAT=3 instances
module tb_simplerisc_dmem_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic req0, req1, we0, we1;
    logic [7:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic g0_1, g1_1, v0_1, v1_1, en_1, we_1, busy_1;
    logic [7:0] ma_1;
    logic [31:0] wd_1, rd_1, mrd_1;
    logic g0_3, g1_3, v0_3, v1_3, en_3, we_3, busy_3;
    logic [7:0] ma_3;
    logic [31:0] wd_3, rd_3, mrd_3;
    logic [7:0] la_1, la_3;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    simplerisc_dmem_arbiter #(.AW(8), .DW(32), .MEM_LAT(1)) d1 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0_1), .gnt1(g1_1), .rvalid0(v0_1), .rvalid1(v1_1), .rdata(rd_1),
        .mem_en(en_1), .mem_we(we_1), .mem_addr(ma_1), .mem_wdata(wd_1),
        .mem_rdata(mrd_1), .busy(busy_1));

    simplerisc_dmem_arbiter #(.AW(8), .DW(32), .MEM_LAT(3)) d3 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0_3), .gnt1(g1_3), .rvalid0(v0_3), .rvalid1(v1_3), .rdata(rd_3),
        .mem_en(en_3), .mem_we(we_3), .mem_addr(ma_3), .mem_wdata(wd_3),
        .mem_rdata(mrd_3), .busy(busy_3));

    function automatic logic [31:0] mem_f(input logic [7:0] a);
        return (a == 8'h20) ? 32'h12345678 : {24'hA5A5A5, a};
    endfunction

    // Memory model: address captured on mem_en, data held until the next access
    always_ff @(posedge clk) begin
        if (en_1) la_1 <= ma_1;
        if (en_3) la_3 <= ma_3;
    end
    assign mrd_1 = mem_f(la_1);
    assign mrd_3 = mem_f(la_3);

    typedef struct {
        logic r0, w0; logic [7:0] a0; logic [31:0] d0;
        logic r1, w1; logic [7:0] a1; logic [31:0] d1;
        logic [5:0] fl; logic [7:0] ea; logic [31:0] ew; logic eb; logic [31:0] er;
    } vec_t;
    vec_t tv [19];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {req0, req1, we0, we1, addr0, addr1, wdata0, wdata1} = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // fl = {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}
        tv[0]  = '{1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[1]  = '{1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 6'b100011, 8'h10, 32'hDEADBEEF, 1, 32'h0};
        tv[2]  = '{0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[3]  = '{0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 6'b010010, 8'h20, 32'h0, 1, 32'h0};
        tv[4]  = '{0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 6'b000000, 8'h00, 32'h0, 1, 32'h0};
        tv[5]  = '{0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 6'b000100, 8'h00, 32'h0, 1, 32'h12345678};
        tv[6]  = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[7]  = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b100011, 8'h40, 32'h11111111, 1, 32'h0};
        tv[8]  = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[9]  = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b010011, 8'h50, 32'h22222222, 1, 32'h0};
        tv[10] = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[11] = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b100011, 8'h40, 32'h11111111, 1, 32'h0};
        tv[12] = '{1, 1, 8'h40, 32'h11111111, 1, 1, 8'h50, 32'h22222222, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[13] = '{0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 6'b010011, 8'h50, 32'h22222222, 1, 32'h0};
        tv[14] = '{1, 1, 8'h30, 32'h33333333, 0, 0, 8'h00, 32'h0, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[15] = '{1, 1, 8'h31, 32'h33333333, 0, 0, 8'h00, 32'h0, 6'b100011, 8'h30, 32'h33333333, 1, 32'h0};
        tv[16] = '{1, 1, 8'h31, 32'h33333333, 0, 0, 8'h00, 32'h0, 6'b000000, 8'h00, 32'h0, 0, 32'h0};
        tv[17] = '{0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 6'b100011, 8'h31, 32'h33333333, 1, 32'h0};
        tv[18] = '{0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 6'b000000, 8'h00, 32'h0, 0, 32'h0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            {req0, we0, addr0, wdata0} = {tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0};
            {req1, we1, addr1, wdata1} = {tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1};
            chk($sformatf("row%0d", i), 64'({g0_1, g1_1, v0_1, v1_1, en_1, we_1, ma_1, wd_1, busy_1}),
                64'({tv[i].fl, tv[i].ea, tv[i].ew, tv[i].eb}));
            if (tv[i].fl[3] | tv[i].fl[2]) chk($sformatf("row%0d_rdata", i), 64'(rd_1), 64'(tv[i].er));
            step();
        end

        // MEM_LAT=3 read on port 0; port 1 raises a write during WAIT
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'h60;
        chk("lat3_idle", 64'(busy_3), 64'(0));
        step();
        chk("lat3_gnt0", 64'({g0_3, en_3, we_3, ma_3}), 64'({1'b1, 1'b1, 1'b0, 8'h60}));
        req0 = 0;
        step();
        req1 = 1; we1 = 1; addr1 = 8'h70; wdata1 = 32'h44444444;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lat3_wait%0d", c), 64'({busy_3, g1_3, v0_3}), 64'(3'b100));
            step();
        end
        chk("lat3_rvalid0", 64'({v0_3, v1_3, g1_3}), 64'(3'b100));
        chk("lat3_rdata", 64'(rd_3), 64'(32'hA5A5A560));
        step();
        chk("lat3_idle_after_resp", 64'({busy_3, g1_3}), 64'(2'b00));
        step();
        chk("lat3_gnt1", 64'({g1_3, ma_3, wd_3}), 64'({1'b1, 8'h70, 32'h44444444}));
        req1 = 0;
        step();

        // Reset while in WAIT aborts the read; afterwards port 0 wins a tie
        do_reset();
        req1 = 1; we1 = 0; addr1 = 8'h20;
        step();
        chk("rst_gnt1", 64'(g1_1), 64'(1));
        step();
        chk("rst_wait_busy", 64'(busy_1), 64'(1));
        reset = 1'b1;
        #1;
        chk("rst_outputs_zero", 64'({g0_1, g1_1, v0_1, v1_1, en_1, we_1, ma_1, wd_1, busy_1}) | 64'(rd_1), 64'(0));
        req0 = 1; we0 = 1; addr0 = 8'h11; we1 = 1; addr1 = 8'h22;
        step();
        chk("rst_no_rvalid", 64'({v1_1, busy_1}), 64'(0));
        reset = 1'b0;
        step();
        chk("rst_tie_port0", 64'({g0_1, g1_1, ma_1}), 64'({2'b10, 8'h11}));
        req0 = 0; req1 = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
